alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle successor to the 32-bit combinational ALU. Adds registered results, NZCV flags, shifts and an iterative shift-add multiplier. Uses a valid/ready handshake on both input and output. Sits between the datapath operand registers and the writeback/flag register, and is driven by the same test-vector style benches.

Parameters:
WIDTH, 32, operand and result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
ALUControl  input  3  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  registered result
flags  output  4  {N,Z,C,V}, registered alongside y

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB (a-b), 010 AND, 011 ORR, 100 EOR.
  - 101 LSL and 110 LSR: shift a by b[SHW-1:0]; upper bits of b are ignored.
  - 111 MUL: low WIDTH bits of unsigned a*b.
- Flags:
  - N = y[WIDTH-1]; Z = (y==0).
  - ADD: C = carry out. SUB: C = NOT borrow (ARM convention, computed as a+~b+1).
  - V = signed overflow for ADD/SUB.
  - Logical ops, shifts and MUL: C=0, V=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiplier iterating, in_ready=0, out_valid=0.
  - DONE: out_valid=1, y/flags held stable.
- Transfers: input accepted on an edge where in_valid&in_ready. Output consumed on an edge where out_valid&out_ready.
- Single-cycle ops: accept at edge k -> DONE, out_valid=1 from edge k.
- MUL: accept at edge k -> BUSY with iteration counter = WIDTH-1. One partial-product bit per cycle, LSB first. Counter==0 -> DONE at edge k+WIDTH.
- DONE: in_ready = out_ready, so a new request may be accepted on the same edge as the result is consumed (back-to-back throughput 1/cycle for single-cycle ops).
  - Consumed with no new request -> IDLE.
  - Consumed with a new single-cycle op -> stays DONE with new y.
  - Consumed with a new MUL -> BUSY.
- Backpressure: while out_valid&!out_ready, y, flags and out_valid hold unchanged and in_ready=0.
- Inputs a/b/ALUControl are captured at acceptance. Changes afterwards have no effect.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Reset (asynchronous, any state including mid-MUL): state=IDLE, y=0, flags=0, out_valid=0, counter=0. Any in-flight result is discarded. in_ready=0 while reset_n=0, 1 on the first cycle after release.
- Arithmetic wraps modulo 2^WIDTH unless the optional feature below is enabled.

Optional Feature:
ALU_SAT_EN
- Defined: ADD/SUB with signed overflow return the saturated value, 2^(WIDTH-1)-1 on positive overflow or -2^(WIDTH-1) on negative overflow. V=1 still reports the overflow. N and Z are computed on the saturated y. C is unchanged.
- Undefined: wrap-around result.
- No port or timing difference either way.

Decomposition:
- Package alu_pkg: enum alu_op_t (3-bit opcodes above), enum alu_state_t {IDLE,BUSY,DONE}, and flag-index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_mul_seq: iterative unsigned shift-add multiplier, parametrised by WIDTH.
  - Ports: clk, reset_n, start, a, b, done, p.
  - Behaviour: done pulses for one cycle WIDTH cycles after start.
- alu_mc holds the FSM, the combinational ADD/SUB/logic/shift path, and the flag generation.

Test Plan:
1. ADD a=7FFFFFFF b=00000001 -> y=80000000, flags N=1 Z=0 C=0 V=1, out_valid one edge after accept. With ALU_SAT_EN: y=7FFFFFFF, V=1, N=0.
2. SUB a=00000005 b=00000005 -> y=00000000, Z=1 C=1 N=0 V=0. SUB a=0 b=1 -> y=FFFFFFFF, N=1 C=0.
3. MUL a=0000FFFF b=00010001 -> y=FFFFFFFF, N=1 C=0 V=0. in_ready=0 and out_valid=0 for 31 cycles, out_valid at edge 32 after accept.
4. Backpressure: ORR a=F0F00000 b=0000F0F0 with out_ready=0 for 5 cycles -> y=F0F0F0F0 stable, in_ready=0 throughout. Then out_ready=1 with LSL a=1 b=00000021 queued -> next y=00000002 (shift by 1) on the following edge.
5. Reset mid-MUL: drop reset_n at cycle 10 of a MUL -> out_valid=0, y=0, flags=0 immediately. After release in_ready=1, and a new ADD 2+3 returns y=5 with no stale MUL result.
6. Back-to-back stream: 100 random single-cycle ops with out_ready=1 -> one result per cycle, matching a reference model including flags, zero mismatches.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] pp;
  logic [CW-1:0]    cnt;
  logic             busy;

  // The final bit is folded into p combinationally so done lands WIDTH cycles after start.
  assign pp   = mplier[0] ? mcand : '0;
  assign p    = acc + pp;
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        acc    <= p;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/NZCV flags and valid/ready handshakes.
// Build option: define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  alu_state_t       state;
  alu_op_t          op;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             sub;
  logic             c_res;
  logic             v_res;
  logic [3:0]       flags_res;
  logic [3:0]       flags_mul;

  assign op        = alu_op_t'(ALUControl);
  assign in_ready  = reset_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .p       (mul_p)
  );

  // SUB is a + ~b + 1 so C comes out as NOT borrow.
  always_comb begin
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    sub   = (op == OP_SUB);
    bx    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    case (op)
      OP_ADD, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        c_res = sum[WIDTH];
        v_res = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (v_res)
          res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
      OP_AND:  res = a & b;
      OP_ORR:  res = a | b;
      OP_EOR:  res = a ^ b;
      OP_LSL:  res = a << b[SHW-1:0];
      OP_LSR:  res = a >> b[SHW-1:0];
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_res         = '0;
    flags_res[FLAG_N] = res[WIDTH-1];
    flags_res[FLAG_Z] = (res == '0);
    flags_res[FLAG_C] = c_res;
    flags_res[FLAG_V] = v_res;
    flags_mul         = '0;
    flags_mul[FLAG_N] = mul_p[WIDTH-1];
    flags_mul[FLAG_Z] = (mul_p == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      y     <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= BUSY;
            end else begin
              state <= DONE;
              y     <= res;
              flags <= flags_res;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (mul_done) begin
            state <= DONE;
            y     <= mul_p;
            flags <= flags_mul;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and model-checked bench for alu_mc (WIDTH=32); honours ALU_SAT_EN.
module tb_alu_mc;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [3:0]  flags;

  int n_cmp;
  int n_fail;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: 64-bit signed arithmetic for overflow, returns {N,Z,C,V,y}.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] z);
    logic [32:0] u;
    longint      s;
    logic [31:0] r;
    logic        c;
    logic        v;
    r = '0; c = 1'b0; v = 1'b0; s = 0;
    case (op)
      3'd0: begin
        u = {1'b0, x} + {1'b0, z};
        r = u[31:0];
        c = u[32];
        s = longint'($signed(x)) + longint'($signed(z));
        v = (s != longint'($signed(r)));
      end
      3'd1: begin
        r = x - z;
        c = (x >= z);
        s = longint'($signed(x)) - longint'($signed(z));
        v = (s != longint'($signed(r)));
      end
      3'd2: r = x & z;
      3'd3: r = x | z;
      3'd4: r = x ^ z;
      3'd5: r = x << z[4:0];
      3'd6: r = x >> z[4:0];
      default: r = x * z;
    endcase
`ifdef ALU_SAT_EN
    if (v) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cycles;
    int          bad;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [35:0] exp_v;

    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 3'd0; a = '0; b = '0;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 32'h0);
    chk("rst_flags", flags, 4'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1'b1);

    // ADD overflow
    ALUControl = 3'd0; a = 32'h7FFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_ov_valid", out_valid, 1'b1);
`ifdef ALU_SAT_EN
    chk("add_ov_y", y, 32'h7FFF_FFFF);
    chk("add_ov_flags", flags, 4'b0001);
`else
    chk("add_ov_y", y, 32'h8000_0000);
    chk("add_ov_flags", flags, 4'b1001);
`endif
    out_ready = 1'b1;
    step();
    chk("add_consumed", out_valid, 1'b0);

    // SUB equal, then SUB 0-1 back to back
    ALUControl = 3'd1; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    step();
    chk("sub_eq", {out_valid, flags, y}, {1'b1, 4'b0110, 32'h0});
    a = 32'd0; b = 32'd1;
    step();
    chk("sub_neg", {out_valid, flags, y}, {1'b1, 4'b1000, 32'hFFFF_FFFF});
    in_valid = 1'b0;
    step();
    chk("sub_idle", out_valid, 1'b0);

    // MUL latency and operand capture
    out_ready = 1'b0;
    ALUControl = 3'd7; a = 32'h0000_FFFF; b = 32'h0001_0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = '0; b = '0;
    cycles = 0; bad = 0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) bad++;
      step();
      cycles++;
    end
    chk("mul_latency", cycles, 32);
    chk("mul_busy_in_ready", bad, 0);
    chk("mul_result", {flags, y}, {4'b1000, 32'hFFFF_FFFF});
    out_ready = 1'b1;
    step();
    chk("mul_consumed", out_valid, 1'b0);

    // Backpressure with a queued LSL
    out_ready = 1'b0;
    ALUControl = 3'd3; a = 32'hF0F0_0000; b = 32'h0000_F0F0; in_valid = 1'b1;
    step();
    ALUControl = 3'd5; a = 32'h1; b = 32'h21;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 32'hF0F0_F0F0 || flags !== 4'b1000) bad++;
      step();
    end
    chk("bp_hold", bad, 0);
    chk("bp_y", y, 32'hF0F0_F0F0);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1'b1);
    step();
    chk("lsl_after_bp", {out_valid, flags, y}, {1'b1, 4'b0000, 32'h0000_0002});
    in_valid = 1'b0;
    step();
    chk("lsl_consumed", out_valid, 1'b0);

    // Reset in the middle of a MUL
    ALUControl = 3'd7; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    #1;
    chk("mrst_state", {in_ready, out_valid, flags, y}, 38'h0);
    step();
    reset_n = 1'b1;
    #1 chk("mrst_ready", in_ready, 1'b1);
    ALUControl = 3'd0; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mrst_add", {out_valid, flags, y}, {1'b1, 4'b0000, 32'd5});
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    chk("mrst_no_stale", bad, 0);

    // Back-to-back random single-cycle stream
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra = pick();
      rb = pick();
      ALUControl = rop; a = ra; b = rb; in_valid = 1'b1;
      if (in_ready !== 1'b1) bad++;
      exp_v = model(rop, ra, rb);
      step();
      chk("stream", {out_valid, flags, y}, {1'b1, exp_v});
    end
    in_valid = 1'b0;
    chk("stream_ready", bad, 0);
    step();
    chk("stream_end", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
